// File: rtl/queue_if.sv
// Sensor/teller inputs and occupancy/wait-time outputs of the bank queue stage.
// err (and its modport entries) exist only when QUEUE_ERR_FLAG_EN is defined.
interface queue_if #(
    parameter int unsigned PCOUNT_W = 3,
    parameter int unsigned WTIME_W  = 5
);
    logic                back_sensor;
    logic                front_sensor;
    logic [1:0]          tcount;
    logic [PCOUNT_W-1:0] pcount;
    logic [WTIME_W-1:0]  wtime;
    logic                full;
    logic                empty;
`ifdef QUEUE_ERR_FLAG_EN
    logic                err;
`endif

    modport master (
        output back_sensor, front_sensor, tcount,
        input  pcount, wtime, full, empty
`ifdef QUEUE_ERR_FLAG_EN
        , input err
`endif
    );

    modport slave (
        input  back_sensor, front_sensor, tcount,
        output pcount, wtime, full, empty
`ifdef QUEUE_ERR_FLAG_EN
        , output err
`endif
    );
endinterface

// File: rtl/queue_controller.sv
// Bank queue occupancy counter and wait-time estimator fed by two photocells.
// Optional sticky illegal-event flag err via QUEUE_ERR_FLAG_EN.
module queue_controller #(
    parameter int unsigned PCOUNT_W = 3,
    parameter int unsigned SVC_TIME = 3,
    parameter int unsigned WTIME_W  = 5
) (
    input logic   clk,
    input logic   rst,
    queue_if.slave q
);
    localparam int unsigned PMAX   = (2 ** PCOUNT_W) - 1;
    localparam int unsigned WMAX   = (2 ** WTIME_W) - 1;
    localparam int unsigned PROD_W = PCOUNT_W + 2 + $clog2(SVC_TIME + 1);

    localparam logic [PCOUNT_W-1:0] PCOUNT_MAX = PCOUNT_W'(PMAX);
    localparam logic [WTIME_W-1:0]  WTIME_SAT  = WTIME_W'(WMAX);

    logic                back_prev;
    logic                front_prev;
    logic [PCOUNT_W-1:0] pcount_q;
    logic [WTIME_W-1:0]  wtime_q;
    logic                full_q;
    logic                empty_q;

    logic                join_ev;
    logic                leave_ev;
    logic [PCOUNT_W-1:0] pn;
    logic [WTIME_W-1:0]  wn;
    logic [PROD_W-1:0]   num;
    logic [PROD_W-1:0]   quo;

    assign join_ev  = q.back_sensor  & ~back_prev;
    assign leave_ev = q.front_sensor & ~front_prev;

    // Next occupancy in priority order; illegal events leave the count alone.
    always_comb begin
        pn = pcount_q;
        if (join_ev && leave_ev) begin
            pn = pcount_q;
        end else if (join_ev && full_q) begin
            pn = pcount_q;
        end else if (leave_ev && empty_q) begin
            pn = pcount_q;
        end else if (leave_ev && (q.tcount == 2'd0)) begin
            pn = pcount_q;
        end else if (join_ev) begin
            pn = pcount_q + PCOUNT_W'(1);
        end else if (leave_ev) begin
            pn = pcount_q - PCOUNT_W'(1);
        end
    end

    // Wait estimate: constant divides by 1/2/3 only, then saturate.
    always_comb begin
        num = PROD_W'(SVC_TIME) * (PROD_W'(pn) + PROD_W'(q.tcount) - PROD_W'(1));
        quo = '0;
        case (q.tcount)
            2'd1:    quo = num;
            2'd2:    quo = num >> 1;
            2'd3:    quo = num / PROD_W'(3);
            default: quo = '0;
        endcase

        wn = '0;
        if (pn == '0) begin
            wn = '0;
        end else if (q.tcount == 2'd0) begin
            wn = WTIME_SAT;
        end else if (32'(quo) > WMAX) begin
            wn = WTIME_SAT;
        end else begin
            wn = WTIME_W'(quo);
        end
    end

    // History regs load the live levels in reset so a held sensor yields no edge.
    always_ff @(posedge clk) begin
        back_prev  <= q.back_sensor;
        front_prev <= q.front_sensor;
        if (rst) begin
            pcount_q <= '0;
            wtime_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            pcount_q <= pn;
            wtime_q  <= wn;
            full_q   <= (pn == PCOUNT_MAX);
            empty_q  <= (pn == '0);
        end
    end

    assign q.pcount = pcount_q;
    assign q.wtime  = wtime_q;
    assign q.full   = full_q;
    assign q.empty  = empty_q;

`ifdef QUEUE_ERR_FLAG_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((join_ev && full_q && !leave_ev) || (leave_ev && empty_q && !join_ev)) begin
            err_q <= 1'b1;
        end
    end

    assign q.err = err_q;
`endif
endmodule

// File: tb/tb_queue_controller.sv
// Directed bench for queue_controller; expected values computed by hand.
module tb_queue_controller;
    localparam int unsigned PCOUNT_W = 3;
    localparam int unsigned SVC_TIME = 3;
    localparam int unsigned WTIME_W  = 5;

    logic clk = 1'b0;
    logic rst;
    int   tests_run = 0;
    int   tests_failed = 0;

    queue_if #(.PCOUNT_W(PCOUNT_W), .WTIME_W(WTIME_W)) qi ();

    queue_controller #(
        .PCOUNT_W(PCOUNT_W),
        .SVC_TIME(SVC_TIME),
        .WTIME_W (WTIME_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q  (qi.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_back(input int n);
        for (int i = 0; i < n; i++) begin
            qi.back_sensor = 1'b1;
            step();
            qi.back_sensor = 1'b0;
            step();
        end
    endtask

    task automatic pulse_front(input int n);
        for (int i = 0; i < n; i++) begin
            qi.front_sensor = 1'b1;
            step();
            qi.front_sensor = 1'b0;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        qi.back_sensor  = 1'b1;
        qi.front_sensor = 1'b0;
        qi.tcount       = 2'd0;
        step();
        step();
        check("rst_pcount", int'(qi.pcount), 0);
        check("rst_wtime",  int'(qi.wtime), 0);
        check("rst_empty",  int'(qi.empty), 1);
        check("rst_full",   int'(qi.full), 0);
`ifdef QUEUE_ERR_FLAG_EN
        check("rst_err",    int'(qi.err), 0);
`endif

        // 1: back sensor held through reset release gives no join
        rst = 1'b0;
        step(); step(); step();
        check("t1_pcount", int'(qi.pcount), 0);
        check("t1_empty",  int'(qi.empty), 1);
        check("t1_wtime",  int'(qi.wtime), 0);
        qi.back_sensor = 1'b0;
        step();

        // 2: one teller, three joins, then three tellers
        qi.tcount = 2'd1;
        pulse_back(3);
        check("t2_pcount", int'(qi.pcount), 3);
        check("t2_wtime",  int'(qi.wtime), 9);
        check("t2_empty",  int'(qi.empty), 0);
        qi.tcount = 2'd3;
        check("t2_wtime_hold", int'(qi.wtime), 9);
        step();
        check("t2_wtime_t3", int'(qi.wtime), 5);

        // 3: saturate at capacity
        do_reset();
        qi.tcount = 2'd2;
        pulse_back(8);
        check("t3_pcount", int'(qi.pcount), 7);
        check("t3_full",   int'(qi.full), 1);
        check("t3_wtime",  int'(qi.wtime), 12);
`ifdef QUEUE_ERR_FLAG_EN
        check("t3_err",    int'(qi.err), 1);
`endif

        // 4: leave while empty
        do_reset();
        qi.tcount = 2'd2;
        pulse_front(1);
        check("t4_pcount", int'(qi.pcount), 0);
        check("t4_empty",  int'(qi.empty), 1);
        check("t4_wtime",  int'(qi.wtime), 0);
`ifdef QUEUE_ERR_FLAG_EN
        check("t4_err",    int'(qi.err), 1);
        do_reset();
        step();
        check("t4_err_clr", int'(qi.err), 0);
`endif

        // 5: simultaneous join/leave, then no tellers
        do_reset();
        qi.tcount = 2'd1;
        pulse_back(4);
        check("t5_pcount4", int'(qi.pcount), 4);
        qi.back_sensor  = 1'b1;
        qi.front_sensor = 1'b1;
        step();
        check("t5_pcount_both", int'(qi.pcount), 4);
        check("t5_wtime_both",  int'(qi.wtime), 12);
        qi.back_sensor  = 1'b0;
        qi.front_sensor = 1'b0;
        step();
        qi.tcount = 2'd0;
        step();
        check("t5_wtime_t0", int'(qi.wtime), 31);
        pulse_front(1);
        check("t5_pcount_t0", int'(qi.pcount), 4);
        check("t5_wtime_sat", int'(qi.wtime), 31);
        check("t5_full",      int'(qi.full), 0);

        // 6: reset on a rising back edge
        qi.tcount = 2'd1;
        pulse_back(1);
        check("t6_pcount5", int'(qi.pcount), 5);
        qi.back_sensor = 1'b1;
        rst            = 1'b1;
        step();
        check("t6_pcount_rst", int'(qi.pcount), 0);
        check("t6_wtime_rst",  int'(qi.wtime), 0);
        rst = 1'b0;
        step();
        check("t6_pcount_rel", int'(qi.pcount), 0);
        qi.back_sensor = 1'b0;
        step();

        // normal decrement with two tellers
        qi.tcount = 2'd2;
        pulse_back(2);
        pulse_front(1);
        check("dec_pcount", int'(qi.pcount), 1);
        check("dec_wtime",  int'(qi.wtime), 3);
        check("dec_empty",  int'(qi.empty), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
